// File: rtl/cam_pkg.sv
// Shared types and constants for the camera-side pixel-stream generator.
// Holds the frame FSM encoding, the RGB565 colour-bar palette and pattern codes.
package cam_pkg;

    typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} cam_tx_state_t;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    localparam logic [1:0] PAT_BARS    = 2'd0;
    localparam logic [1:0] PAT_RAMP    = 2'd1;
    localparam logic [1:0] PAT_SOLID   = 2'd2;
    localparam logic [1:0] PAT_CHECKER = 2'd3;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cam_stream_gen_pattern.sv
// Combinational test-pattern source: active pixel (x, y) -> RGB565 colour.
module cam_pattern_gen #(
    parameter int H_ACTIVE = 160,
    parameter int XW       = 9,
    parameter int YW       = 7
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [1:0]    sel,
    input  logic [15:0]   solid,
    output logic [15:0]   rgb
);
    import cam_pkg::*;

    localparam int BAR_W = H_ACTIVE / 8;

    logic [15:0] xe, ye;
    logic [2:0]  bar;
    logic        unused_ybits;

    assign xe  = 16'(x);
    assign ye  = 16'(y);
    assign bar = 3'(xe / 16'(BAR_W));
    // Only the low row bits feed the ramp and checker patterns.
    assign unused_ybits = ^ye[15:6];

    always_comb begin
        rgb = 16'h0000;
        case (sel)
            PAT_BARS:  rgb = bar_color(bar);
            PAT_RAMP:  rgb = {xe[4:0], ye[5:0], ~xe[4:0]};
            PAT_SOLID: rgb = solid;
            default:   rgb = (xe[3] ^ ye[3]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style transmitter: pclk = clk/2, frame FSM and byte-serialised RGB565.
// Everything but pclk/frame_done advances on the tick (pclk high) cycle.
module cam_stream_gen #(
    parameter int H_ACTIVE    = 160,
    parameter int V_ACTIVE    = 120,
    parameter int H_BLANK     = 16,
    parameter int VSYNC_LINES = 3,
    parameter int V_BACK      = 2,
    parameter int V_FRONT     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    input  logic [15:0] solid_color,
    output logic        pclk,
    output logic        vsync,
    output logic        href,
    output logic [7:0]  px_data,
    output logic        frame_done,
    output logic        busy
);
    import cam_pkg::*;

    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int VM1 = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
    localparam int VM2 = (V_ACTIVE > V_FRONT) ? V_ACTIVE : V_FRONT;
    localparam int V_MAX = (VM1 > VM2) ? VM1 : VM2;
    localparam int HW = $clog2(LINE_LEN + 1);
    localparam int VW = $clog2(V_MAX + 1);

    cam_tx_state_t state, nxt_state;
    logic [HW-1:0] hc, nxt_hc;
    logic [VW-1:0] vc, nxt_vc, last_vc;
    logic [1:0]    sel_q;
    logic [15:0]   solid_q, rgb;
    logic          tick, line_end, state_end, nxt_href, latch;

    assign tick      = pclk;
    assign busy      = (state != IDLE);
    assign line_end  = (hc == HW'(LINE_LEN - 1));
    assign state_end = line_end && (vc == last_vc);
    assign latch     = enable && (state == IDLE || (state == VFRONT && state_end));

    always_comb begin
        case (state)
            VSYNC:   last_vc = VW'(VSYNC_LINES - 1);
            VBACK:   last_vc = VW'(V_BACK - 1);
            ACTIVE:  last_vc = VW'(V_ACTIVE - 1);
            VFRONT:  last_vc = VW'(V_FRONT - 1);
            default: last_vc = '0;
        endcase
    end

    always_comb begin
        nxt_state = state;
        nxt_hc    = hc;
        nxt_vc    = vc;
        if (state == IDLE) begin
            if (enable) begin
                nxt_state = VSYNC;
                nxt_hc    = '0;
                nxt_vc    = '0;
            end
        end else begin
            nxt_hc = line_end ? '0 : hc + HW'(1);
            if (line_end) nxt_vc = state_end ? '0 : vc + VW'(1);
            if (state_end) begin
                case (state)
                    VSYNC:   nxt_state = VBACK;
                    VBACK:   nxt_state = ACTIVE;
                    ACTIVE:  nxt_state = VFRONT;
                    default: nxt_state = enable ? VSYNC : IDLE;
                endcase
            end
        end
    end

    // Outputs are registered from the next-state view so they line up with hc/vc.
    assign nxt_href = (nxt_state == ACTIVE) && (nxt_hc < HW'(2 * H_ACTIVE));

    cam_pattern_gen #(.H_ACTIVE(H_ACTIVE), .XW(HW), .YW(VW)) u_pattern (
        .x     (nxt_hc >> 1),
        .y     (nxt_vc),
        .sel   (sel_q),
        .solid (solid_q),
        .rgb   (rgb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk       <= 1'b0;
            state      <= IDLE;
            hc         <= '0;
            vc         <= '0;
            vsync      <= 1'b0;
            href       <= 1'b0;
            px_data    <= 8'h00;
            frame_done <= 1'b0;
            sel_q      <= 2'd0;
            solid_q    <= 16'h0000;
        end else begin
            pclk       <= ~pclk;
            // Registered one cycle early so the pulse sits in the final VFRONT tick.
            frame_done <= ~pclk && (state == VFRONT) && state_end;
            if (tick) begin
                state   <= nxt_state;
                hc      <= nxt_hc;
                vc      <= nxt_vc;
                vsync   <= (nxt_state == VSYNC);
                href    <= nxt_href;
                px_data <= nxt_href ? (nxt_hc[0] ? rgb[7:0] : rgb[15:8]) : 8'h00;
                if (latch) begin
                    sel_q   <= pattern_sel;
                    solid_q <= solid_color;
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Self-checking bench: outputs compared each clk against a frame-timing model
// computed from tick index within the frame.
module tb_cam_stream_gen;
    localparam int HA = 8, VA = 4, HB = 4, VS = 1, VB = 1, VF = 1;
    localparam int LL = 2 * HA + HB;
    localparam int FT = (VS + VB + VA + VF) * LL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [15:0] solid_color = 16'h0000;
    logic        pclk, vsync, href, frame_done, busy;
    logic [7:0]  px_data;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int nfr = 0;
    logic [1:0]  fr_sel   [16];
    logic [15:0] fr_solid [16];
    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0] line_exp [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    cam_stream_gen #(.H_ACTIVE(HA), .V_ACTIVE(VA), .H_BLANK(HB),
                     .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)) dut (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .solid_color(solid_color), .pclk(pclk), .vsync(vsync), .href(href),
        .px_data(px_data), .frame_done(frame_done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pat(input int x, input int y, input logic [1:0] s,
                                        input logic [15:0] sol);
        logic [15:0] xv, yv;
        xv = x[15:0];
        yv = y[15:0];
        case (s)
            2'd0:    return bars[x / (HA / 8)];
            2'd1:    return {xv[4:0], yv[5:0], ~xv[4:0]};
            2'd2:    return sol;
            default: return (((x / 8) + (y / 8)) % 2 == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // n = clk edges since reset release; outputs move on even edges >= 2.
    task automatic model(input int nn, output logic ep, output logic ev, output logic eh,
                         output logic ef, output logic eb, output logic [7:0] ex);
        int t, p, ln, col;
        logic [15:0] c;
        ep = ((nn % 2) == 1);
        {ev, eh, ef, eb, ex} = '0;
        if (nn >= 2) begin
            t = (nn - 2) / 2;
            if (t / FT < nfr) begin
                p = t % FT; ln = p / LL; col = p % LL;
                eb = 1'b1;
                ev = (ln < VS);
                if (ln >= VS + VB && ln < VS + VB + VA && col < 2 * HA) begin
                    eh = 1'b1;
                    c = pat(col / 2, ln - VS - VB, fr_sel[t / FT], fr_solid[t / FT]);
                    ex = (col % 2 == 0) ? c[15:8] : c[7:0];
                end
                ef = ((nn % 2) == 1) && (p == FT - 1);
            end
        end
    endtask

    // Records the inputs that the DUT latches at frame-start ticks, then steps one clk.
    task automatic advance();
        int t;
        if (n + 1 >= 2 && ((n + 1) % 2) == 0) begin
            t = (n + 1 - 2) / 2;
            if (t % FT == 0 && t / FT < 16) begin
                fr_sel[t / FT]   = pattern_sel;
                fr_solid[t / FT] = solid_color;
            end
        end
        @(posedge clk);
        n++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
    endtask

    task automatic test_reset();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        enable = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pclk, vsync, href, frame_done, busy, px_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset_values got pclk=%b vs=%b hr=%b fd=%b busy=%b px=%h want all 0",
                     pclk, vsync, href, frame_done, busy, px_data);
        end
        rst = 1'b0; n = 0; nfr = 0;
        repeat (12) begin
            advance();
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL idle_disabled n=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, pclk, vsync, href, frame_done, busy, px_data, ep, ev, eh, ef, eb, ex);
            end
        end
    endtask

    task automatic test_bars();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        logic prev_p, prev_h, prev_v;
        int pulses, edges, bidx, vs_n, fd_n, fd_cnt, vs_cnt;
        pattern_sel = 2'd0; enable = 1'b1; nfr = 99;
        do_reset();
        prev_p = 0; prev_h = 0; prev_v = 0;
        pulses = 0; edges = 0; bidx = 0; vs_n = -1; fd_n = -1; fd_cnt = 0; vs_cnt = 0;
        while (n < 2 * FT + 40) begin
            advance();
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL bars_stream n=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, pclk, vsync, href, frame_done, busy, px_data, ep, ev, eh, ef, eb, ex);
            end
            checks++;
            if ((href && vsync) || (!href && px_data !== 8'h00) || (frame_done && href)) begin
                errors++;
                $display("FAIL bars_property n=%0d hr=%b vs=%b fd=%b px=%h", n, href, vsync,
                         frame_done, px_data);
            end
            if (n < 2 * FT + 2) begin
                if (vsync) vs_cnt++;
                if (frame_done) begin fd_cnt++; fd_n = n; end
                if (href && !prev_h) begin pulses++; edges = 0; end
                if (href && pclk && !prev_p) begin
                    edges++;
                    if (pulses == 1 && bidx < 16) begin
                        checks++;
                        if (px_data !== line_exp[bidx]) begin
                            errors++;
                            $display("FAIL bars_line0_byte%0d got %h want %h", bidx, px_data,
                                     line_exp[bidx]);
                        end
                        bidx++;
                    end
                end
                if (!href && prev_h) begin
                    checks++;
                    if (edges != 16) begin
                        errors++;
                        $display("FAIL bars_href_edges line=%0d got %0d want 16", pulses, edges);
                    end
                end
                if (vsync && !prev_v && vs_n < 0) vs_n = n;
            end
            prev_p = pclk; prev_h = href; prev_v = vsync;
        end
        checks++;
        if (pulses != VA) begin errors++; $display("FAIL bars_href_pulses got %0d want %0d", pulses, VA); end
        checks++;
        if (vs_n != 2) begin errors++; $display("FAIL bars_first_vsync got edge %0d want 2", vs_n); end
        checks++;
        if (vs_cnt != 2 * VS * LL) begin
            errors++; $display("FAIL bars_vsync_len got %0d clk want %0d", vs_cnt, 2 * VS * LL);
        end
        checks++;
        if (fd_cnt != 1 || fd_n - vs_n != 2 * FT - 1) begin
            errors++;
            $display("FAIL bars_frame_done count=%0d offset=%0d want 1 and %0d", fd_cnt,
                     fd_n - vs_n, 2 * FT - 1);
        end
    endtask

    task automatic test_solid_latch();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        int t;
        pattern_sel = 2'd2; solid_color = 16'hF81F; enable = 1'b1; nfr = 99;
        do_reset();
        while (n < 2 * FT + 140) begin
            advance();
            if (n == 100) solid_color = 16'h07E0;
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL solid_stream n=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, pclk, vsync, href, frame_done, busy, px_data, ep, ev, eh, ef, eb, ex);
            end
            if (href) begin
                t = (n - 2) / 2;
                checks++;
                if (px_data !== ((t / FT == 0) ? (((t % LL) % 2 == 0) ? 8'hF8 : 8'h1F)
                                              : (((t % LL) % 2 == 0) ? 8'h07 : 8'hE0))) begin
                    errors++;
                    $display("FAIL solid_latch n=%0d frame=%0d got %h", n, t / FT, px_data);
                end
            end
        end
    endtask

    task automatic test_enable_drop();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        int fd_cnt;
        pattern_sel = 2'($urandom_range(0, 3)); solid_color = 16'($urandom);
        enable = 1'b1; nfr = 1; fd_cnt = 0;
        do_reset();
        while (n < 2 * FT + 80) begin
            advance();
            if (n == 2 + 2 * ((VS + VB + 1) * LL + 5)) enable = 1'b0;
            if (frame_done) fd_cnt++;
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL enable_drop n=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, pclk, vsync, href, frame_done, busy, px_data, ep, ev, eh, ef, eb, ex);
            end
        end
        checks++;
        if (fd_cnt != 1 || busy !== 1'b0 || vsync !== 1'b0 || href !== 1'b0) begin
            errors++;
            $display("FAIL enable_drop_idle fd=%0d busy=%b vs=%b hr=%b want 1 0 0 0",
                     fd_cnt, busy, vsync, href);
        end
    endtask

    task automatic test_rst_mid_href();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        int target;
        pattern_sel = 2'd3; enable = 1'b1; nfr = 99;
        do_reset();
        target = 2 + 2 * ((VS + VB) * LL) + $urandom_range(0, 200);
        while (n < 600 && !(href && n >= target)) advance();
        checks++;
        if (!href) begin
            errors++;
            $display("FAIL rst_mid_href_wait got href=%b want 1 within budget", href);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pclk, vsync, href, frame_done, busy, px_data} !== 13'h0) begin
            errors++;
            $display("FAIL rst_mid_href_values got %b%b%b%b%b %h want all 0",
                     pclk, vsync, href, frame_done, busy, px_data);
        end
        rst = 1'b0; n = 0;
        while (n < 2 * (VS + VB + 1) * LL) begin
            advance();
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL rst_restart n=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, pclk, vsync, href, frame_done, busy, px_data, ep, ev, eh, ef, eb, ex);
            end
        end
    endtask

    task automatic test_random_patterns();
        logic ep, ev, eh, ef, eb; logic [7:0] ex;
        pattern_sel = 2'($urandom_range(0, 3)); solid_color = 16'($urandom);
        enable = 1'b1; nfr = 99;
        do_reset();
        while (n < 2 * FT * 4 + 4) begin
            advance();
            if ($urandom_range(0, 39) == 0) begin
                pattern_sel = 2'($urandom_range(0, 3));
                solid_color = 16'($urandom);
            end
            model(n, ep, ev, eh, ef, eb, ex);
            checks++;
            if ({pclk, vsync, href, frame_done, busy, px_data} !== {ep, ev, eh, ef, eb, ex}) begin
                errors++;
                $display("FAIL random_pat n=%0d sel=%0d got %b%b%b%b%b %h want %b%b%b%b%b %h",
                         n, fr_sel[((n - 2) / 2) / FT], pclk, vsync, href, frame_done, busy,
                         px_data, ep, ev, eh, ef, eb, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_bars();
        test_solid_latch();
        test_enable_drop();
        test_rst_mid_href();
        test_random_patterns();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
